// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide unit with fixed-latency busy sequencing for the E stage.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are built when MDU_MADD_EN is defined.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PROD_W = 64;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   pend_hi_q, pend_hi_d;
  logic [DATA_W-1:0]   pend_lo_q, pend_lo_d;
  logic                pend_wr_q, pend_wr_d;

  // Datapath results computed from the operands presented at issue.
  logic [PROD_W-1:0]   prod_s;
  logic [PROD_W-1:0]   prod_u;
  logic [DATA_W-1:0]   rt_safe;
  logic [DATA_W-1:0]   quo_u, rem_u;
  logic [DATA_W-1:0]   rs_abs, rt_abs, rt_abs_safe;
  logic [DATA_W-1:0]   quo_mag, rem_mag;
  logic [DATA_W-1:0]   quo_s, rem_s;
`ifdef MDU_MADD_EN
  logic [PROD_W-1:0]   acc_base;
  logic [PROD_W-1:0]   madd_s, maddu, msub_s, msubu;
`endif

  always_comb begin
    prod_s = {{DATA_W{rs[DATA_W-1]}}, rs} * {{DATA_W{rt[DATA_W-1]}}, rt};
    prod_u = {{DATA_W{1'b0}}, rs} * {{DATA_W{1'b0}}, rt};
  end

  // Signed divide via magnitudes: quotient truncates toward zero, remainder follows dividend sign.
  // A zero divisor is replaced by one so the divider never sees it; the result is discarded anyway.
  always_comb begin
    rt_safe     = (rt == '0) ? DATA_W'(1) : rt;
    quo_u       = rs / rt_safe;
    rem_u       = rs % rt_safe;
    rs_abs      = rs[DATA_W-1] ? (~rs + DATA_W'(1)) : rs;
    rt_abs      = rt[DATA_W-1] ? (~rt + DATA_W'(1)) : rt;
    rt_abs_safe = (rt_abs == '0) ? DATA_W'(1) : rt_abs;
    quo_mag     = rs_abs / rt_abs_safe;
    rem_mag     = rs_abs % rt_abs_safe;
    quo_s       = (rs[DATA_W-1] ^ rt[DATA_W-1]) ? (~quo_mag + DATA_W'(1)) : quo_mag;
    rem_s       = rs[DATA_W-1] ? (~rem_mag + DATA_W'(1)) : rem_mag;
  end

`ifdef MDU_MADD_EN
  // Accumulate base is the committed {hi,lo} at issue time.
  always_comb begin
    acc_base = {hi_q, lo_q};
    madd_s   = acc_base + prod_s;
    maddu    = acc_base + prod_u;
    msub_s   = acc_base - prod_s;
    msubu    = acc_base - prod_u;
  end
`endif

  // Next-state and datapath-register control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LOAD;
              state_d   = ST_RUN;
              busy_d    = 1'b1;
            end
            OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LOAD;
              state_d   = ST_RUN;
              busy_d    = 1'b1;
            end
            OP_DIV: begin
              pend_hi_d = rem_s;
              pend_lo_d = quo_s;
              pend_wr_d = (rt != '0);
              cnt_d     = DIV_LOAD;
              state_d   = ST_RUN;
              busy_d    = 1'b1;
            end
            OP_DIVU: begin
              pend_hi_d = rem_u;
              pend_lo_d = quo_u;
              pend_wr_d = (rt != '0);
              cnt_d     = DIV_LOAD;
              state_d   = ST_RUN;
              busy_d    = 1'b1;
            end
            OP_MTHI: hi_d = rs;
            OP_MTLO: lo_d = rs;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              case (md_op)
                OP_MADD:  {pend_hi_d, pend_lo_d} = madd_s;
                OP_MADDU: {pend_hi_d, pend_lo_d} = maddu;
                OP_MSUB:  {pend_hi_d, pend_lo_d} = msub_s;
                default:  {pend_hi_d, pend_lo_d} = msubu;
              endcase
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LOAD;
              state_d   = ST_RUN;
              busy_d    = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign stall_req = (start | busy_q) & md_use_d;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed vector bench for mdu_ctrl: table of single ops plus multi-cycle corner sequences.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        md_use_d;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_BAD   = 4'd15;

  localparam int NVEC = 18;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    logic [31:0] h;
    logic [31:0] l;
  } vec_t;

  vec_t vecs [NVEC];

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .rs        (rs),
    .rt        (rt),
    .md_use_d  (md_use_d),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge: issues op across the next posedge, then counts busy cycles.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    start = 1'b1;
    md_op = op;
    rs    = a;
    rt    = b;
    @(negedge clk);
    start = 1'b0;
    md_op = OP_NONE;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    start    = 1'b0;
    md_op    = OP_NONE;
    rs       = '0;
    rt       = '0;
    md_use_d = 1'b0;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        5,  32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{OP_DIVU,  32'd7,        32'd2,        10, 32'h00000001, 32'h00000003};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[4]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
    vecs[5]  = '{OP_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
    vecs[6]  = '{OP_MTHI,  32'h00001234, 32'd0,        0,  32'h00001234, 32'h00000000};
    vecs[7]  = '{OP_MTLO,  32'h00000055, 32'd0,        0,  32'h00001234, 32'h00000055};
    vecs[8]  = '{OP_DIV,   32'd5,        32'd0,        10, 32'h00001234, 32'h00000055};
    vecs[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 10, 32'h0000000F, 32'h0FFFFFFF};
    vecs[11] = '{OP_NONE,  32'd9,        32'd9,        0,  32'h0000000F, 32'h0FFFFFFF};
    vecs[12] = '{OP_BAD,   32'd9,        32'd9,        0,  32'h0000000F, 32'h0FFFFFFF};
    vecs[13] = '{OP_MTHI,  32'h00000000, 32'd0,        0,  32'h00000000, 32'h0FFFFFFF};
    vecs[14] = '{OP_MTLO,  32'hFFFFFFFF, 32'd0,        0,  32'h00000000, 32'hFFFFFFFF};
`ifdef MDU_MADD_EN
    vecs[15] = '{OP_MADDU, 32'd1,        32'd1,        5,  32'h00000001, 32'h00000000};
    vecs[16] = '{OP_MSUB,  32'd3,        32'd2,        5,  32'h00000000, 32'hFFFFFFFA};
`else
    vecs[15] = '{OP_MADDU, 32'd1,        32'd1,        0,  32'h00000000, 32'hFFFFFFFF};
    vecs[16] = '{OP_MSUB,  32'd3,        32'd2,        0,  32'h00000000, 32'hFFFFFFFF};
`endif
    vecs[17] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'h00000000, 32'h00000001};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);

    // stall_req is combinational on start/busy/md_use_d
    md_use_d = 1'b1;
    #1 chk("stall_idle", 64'(stall_req), 64'd0);
    start = 1'b1;
    #1 chk("stall_start", 64'(stall_req), 64'd1);
    start = 1'b0;
    md_use_d = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
      chk($sformatf("vec%0d_cycles", i), 64'(n), 64'(vecs[i].n));
      chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].h));
      chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].l));
    end

    // Back-to-back: second op issued in the first cycle busy is low.
    run_op(OP_MULTU, 32'd2, 32'd3, n);
    chk("b2b_first_cycles", 64'(n), 64'd5);
    chk("b2b_first_lo", 64'(lo), 64'd6);
    run_op(OP_DIVU, 32'd100, 32'd7, n);
    chk("b2b_second_cycles", 64'(n), 64'd10);
    chk("b2b_second_hi", 64'(hi), 64'd2);
    chk("b2b_second_lo", 64'(lo), 64'd14);

    // Start while busy (mtlo at busy cycle 2) must be ignored.
    start = 1'b1;
    md_op = OP_MULTU;
    rs    = 32'hFFFFFFFF;
    rt    = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    md_op = OP_NONE;
    md_use_d = 1'b1;
    #1 chk("stall_busy", 64'(stall_req), 64'd1);
    md_use_d = 1'b0;
    #1 chk("stall_busy_no_use", 64'(stall_req), 64'd0);
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 2) begin
        start = 1'b1;
        md_op = OP_MTLO;
        rs    = 32'hAA;
      end else begin
        start = 1'b0;
        md_op = OP_NONE;
      end
      @(negedge clk);
      if (n == 2) chk("ignore_lo_mid", 64'(lo), 64'd14);
    end
    start = 1'b0;
    md_op = OP_NONE;
    chk("ignore_cycles", 64'(n), 64'd5);
    chk("ignore_hi", 64'(hi), 64'hFFFFFFFE);
    chk("ignore_lo", 64'(lo), 64'h00000001);

    // Reset during busy cycle 4 of a divide aborts it with no later write.
    start = 1'b1;
    md_op = OP_DIV;
    rs    = 32'd9;
    rt    = 32'd2;
    @(negedge clk);
    start = 1'b0;
    md_op = OP_NONE;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    repeat (15) @(negedge clk);
    chk("abort_late_busy", 64'(busy), 64'd0);
    chk("abort_late_hi", 64'(hi), 64'd0);
    chk("abort_late_lo", 64'(lo), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
